// File: rtl/ellipse_free_circle_mask.sv
// Streaming circular pixel mask with frame-shadowed config, auto centre, invert and a per-row sqrt bound.
// Optional build macro CIRCLE_MASK_STATS_EN adds pass_count/stats_valid per-frame statistics.
`timescale 1ns/1ps

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h02
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 8'h04
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h08
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'h10
`endif

module ellipse_free_circle_mask #(
   parameter int PIXEL_WIDTH = 10,
   parameter int NUM_CHAN    = 3,
   parameter int DIM_WIDTH   = 12
) (
   input  logic                            clk,
   input  logic                            resetb,
   input  logic                            enable,
   input  logic                            auto_center,
   input  logic                            invert,
   input  logic [DIM_WIDTH-1:0]            center_col,
   input  logic [DIM_WIDTH-1:0]            center_row,
   input  logic [DIM_WIDTH-1:0]            radius,
   input  logic [PIXEL_WIDTH-1:0]          fill,
   input  logic                            dvi,
   input  logic [NUM_CHAN*PIXEL_WIDTH-1:0] datai,
   input  logic [`DTYPE_WIDTH-1:0]         dtypei,
   input  logic [15:0]                     meta_datai,
   output logic                            dvo,
   output logic [NUM_CHAN*PIXEL_WIDTH-1:0] datao,
   output logic [`DTYPE_WIDTH-1:0]         dtypeo,
   output logic [15:0]                     meta_datao,
   output logic                            late_bound
`ifdef CIRCLE_MASK_STATS_EN
   ,
   output logic [2*DIM_WIDTH-1:0]          pass_count,
   output logic                            stats_valid
`endif
);

   localparam int DW = DIM_WIDTH;
   localparam int SW = DIM_WIDTH + 1;
   localparam int RW = DIM_WIDTH + 2;
   localparam int CW = $clog2(DIM_WIDTH + 1);

   typedef enum logic [1:0] {SQ_IDLE, SQ_CALC, SQ_DONE} sq_state_t;

   function automatic logic signed [SW-1:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic signed [SW-1:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return (d < 0) ? -d : d;
   endfunction

   // Stage p0: beat decode, shadows, counters, row bound
   logic frame_start_p0, frame_end_p0, row_start_p0, row_end_p0, pix_p0;
   assign frame_start_p0 = dvi && (dtypei == `DTYPE_FRAME_START);
   assign frame_end_p0   = dvi && (dtypei == `DTYPE_FRAME_END);
   assign row_start_p0   = dvi && (dtypei == `DTYPE_ROW_START);
   assign row_end_p0     = dvi && (dtypei == `DTYPE_ROW_END);
   assign pix_p0         = dvi && (dtypei == `DTYPE_PIXEL_MASK);

   logic                   en_s, inv_s, full_s;
   logic [DW-1:0]          r_s, cx_s, cy_s;
   logic [PIXEL_WIDTH-1:0] fill_s;
   logic [DW-1:0]          row, col, cols_meas, rows_meas;

   // Centre is frozen at frame start so mid-frame ROW_END updates of cols_meas cannot move it.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         en_s   <= 1'b0;
         inv_s  <= 1'b0;
         full_s <= 1'b0;
         r_s    <= '0;
         cx_s   <= '0;
         cy_s   <= '0;
         fill_s <= '0;
      end else if (frame_start_p0) begin
         en_s   <= enable;
         inv_s  <= invert;
         r_s    <= radius;
         fill_s <= fill;
         full_s <= auto_center && ((cols_meas == '0) || (rows_meas == '0));
         cx_s   <= auto_center ? (cols_meas >> 1) : center_col;
         cy_s   <= auto_center ? (rows_meas >> 1) : center_row;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         row       <= '0;
         col       <= '0;
         cols_meas <= '0;
         rows_meas <= '0;
      end else if (frame_start_p0) begin
         row <= '0;
         col <= '0;
      end else if (pix_p0) begin
         col <= col + 1'b1;
      end else if (row_end_p0) begin
         cols_meas <= col;
         col       <= '0;
         row       <= row + 1'b1;
      end else if (frame_end_p0) begin
         rows_meas <= row;
      end
   end

   logic signed [SW-1:0] dy_p0;
   logic                 row_far_p0;
   logic [DW-1:0]        dy_u_p0;
   logic [2*DW-1:0]      r_sq_p0, dy_sq_p0, s_p0;

   assign dy_p0      = abs_diff(row, cy_s);
   assign row_far_p0 = dy_p0 > $signed({1'b0, r_s});
   assign dy_u_p0    = dy_p0[DW-1:0];
   assign r_sq_p0    = {{DW{1'b0}}, r_s} * {{DW{1'b0}}, r_s};
   assign dy_sq_p0   = {{DW{1'b0}}, dy_u_p0} * {{DW{1'b0}}, dy_u_p0};
   assign s_p0       = r_sq_p0 - dy_sq_p0;

   // Restoring square root: consumes two radicand bits and produces one root bit per CALC cycle
   sq_state_t       sq_state, sq_next;
   logic [CW-1:0]   sq_cnt;
   logic [2*DW-1:0] sq_rad;
   logic [RW-1:0]   sq_rem, sq_rem_nxt;
   logic [DW-1:0]   sq_root, sq_root_nxt, hw;
   logic [RW+1:0]   sq_rem_sh, sq_trial;
   logic            bound_valid, row_out;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) sq_state <= SQ_IDLE;
      else         sq_state <= sq_next;
   end

   always_comb begin
      sq_next = sq_state;
      unique case (sq_state)
         SQ_IDLE: sq_next = SQ_IDLE;
         SQ_CALC: if (sq_cnt == CW'(DW - 1)) sq_next = SQ_DONE;
         SQ_DONE: sq_next = SQ_IDLE;
         default: sq_next = SQ_IDLE;
      endcase
      if (row_start_p0) sq_next = row_far_p0 ? SQ_IDLE : SQ_CALC;
   end

   always_comb begin
      sq_rem_sh = {sq_rem, sq_rad[2*DW-1 -: 2]};
      sq_trial  = {2'b00, sq_root, 2'b01};
      if (sq_rem_sh >= sq_trial) begin
         sq_rem_nxt  = RW'(sq_rem_sh - sq_trial);
         sq_root_nxt = {sq_root[DW-2:0], 1'b1};
      end else begin
         sq_rem_nxt  = sq_rem_sh[RW-1:0];
         sq_root_nxt = {sq_root[DW-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (row_start_p0) begin
         sq_rad  <= s_p0;
         sq_rem  <= '0;
         sq_root <= '0;
      end else if (sq_state == SQ_CALC) begin
         sq_rad  <= sq_rad << 2;
         sq_rem  <= sq_rem_nxt;
         sq_root <= sq_root_nxt;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         sq_cnt      <= '0;
         bound_valid <= 1'b0;
         row_out     <= 1'b0;
         hw          <= '0;
      end else if (row_start_p0) begin
         sq_cnt      <= '0;
         bound_valid <= 1'b0;
         row_out     <= row_far_p0;
      end else if (sq_state == SQ_CALC) begin
         sq_cnt <= sq_cnt + 1'b1;
      end else if (sq_state == SQ_DONE) begin
         hw          <= sq_root;
         bound_valid <= 1'b1;
      end
   end

   logic signed [SW-1:0] dx_p0;
   logic                 inside_p0, pass_p0, masked_p0, late_set_p0;

   assign dx_p0       = abs_diff(col, cx_s);
   assign inside_p0   = !row_out && bound_valid && (dx_p0 <= $signed({1'b0, hw}));
   assign pass_p0     = full_s || (inside_p0 ^ inv_s);
   assign masked_p0   = pix_p0 && en_s && !pass_p0;
   assign late_set_p0 = pix_p0 && en_s && !full_s && !row_out && !bound_valid;

   // Stage p1: registered outputs
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         dvo        <= 1'b0;
         datao      <= '0;
         dtypeo     <= '0;
         meta_datao <= '0;
         late_bound <= 1'b0;
      end else begin
         dvo        <= dvi;
         datao      <= masked_p0 ? {NUM_CHAN{fill_s}} : datai;
         dtypeo     <= dtypei;
         meta_datao <= meta_datai;
         if (frame_start_p0)   late_bound <= 1'b0;
         else if (late_set_p0) late_bound <= 1'b1;
      end
   end

`ifdef CIRCLE_MASK_STATS_EN
   logic [2*DW-1:0] pass_acc;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         pass_acc    <= '0;
         pass_count  <= '0;
         stats_valid <= 1'b0;
      end else begin
         stats_valid <= frame_end_p0;
         if (frame_start_p0)            pass_acc <= '0;
         else if (pix_p0 && !masked_p0) pass_acc <= pass_acc + 1'b1;
         if (frame_end_p0)              pass_count <= pass_acc;
      end
   end
`endif

endmodule

// File: tb/tb_ellipse_free_circle_mask.sv
// Self-checking bench for ellipse_free_circle_mask: directed frames, probe tables and random frames
// against a squared-distance reference model; checks stats ports when CIRCLE_MASK_STATS_EN is defined.
`timescale 1ns/1ps

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h02
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 8'h04
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h08
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'h10
`endif

module tb_ellipse_free_circle_mask;

   localparam int PW = 10;
   localparam int NC = 3;
   localparam int DW = 12;
   localparam logic [`DTYPE_WIDTH-1:0] FS = `DTYPE_FRAME_START;
   localparam logic [`DTYPE_WIDTH-1:0] FE = `DTYPE_FRAME_END;
   localparam logic [`DTYPE_WIDTH-1:0] RS = `DTYPE_ROW_START;
   localparam logic [`DTYPE_WIDTH-1:0] RE = `DTYPE_ROW_END;
   localparam logic [`DTYPE_WIDTH-1:0] PX = `DTYPE_PIXEL_MASK;

   logic clk = 1'b0;
   logic resetb, enable, auto_center, invert, dvi;
   logic [DW-1:0] center_col, center_row, radius;
   logic [PW-1:0] fill;
   logic [NC*PW-1:0] datai, datao;
   logic [`DTYPE_WIDTH-1:0] dtypei, dtypeo;
   logic [15:0] meta_datai, meta_datao;
   logic dvo, late_bound;
`ifdef CIRCLE_MASK_STATS_EN
   logic [2*DW-1:0] pass_count;
   logic stats_valid;
`endif

   ellipse_free_circle_mask #(.PIXEL_WIDTH(PW), .NUM_CHAN(NC), .DIM_WIDTH(DW)) dut (
      .clk(clk), .resetb(resetb), .enable(enable), .auto_center(auto_center), .invert(invert),
      .center_col(center_col), .center_row(center_row), .radius(radius), .fill(fill),
      .dvi(dvi), .datai(datai), .dtypei(dtypei), .meta_datai(meta_datai),
      .dvo(dvo), .datao(datao), .dtypeo(dtypeo), .meta_datao(meta_datao), .late_bound(late_bound)
`ifdef CIRCLE_MASK_STATS_EN
      , .pass_count(pass_count), .stats_valid(stats_valid)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_row, m_col, m_cols_meas, m_rows_meas, m_cx, m_cy, m_r, m_dy, m_rs_t, m_cnt, cyc;
   bit m_en, m_inv, m_full, m_far, m_late;
   logic [PW-1:0] m_fill;
   int cap_sel = -1;
   bit rec [0:3][0:15][0:15];

   typedef struct { int row; int col; bit pass; } probe_t;
   probe_t tbl [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   task automatic model_reset();
      m_row = 0; m_col = 0; m_cols_meas = 0; m_rows_meas = 0;
      m_cx = 0; m_cy = 0; m_r = 0; m_dy = 0; m_rs_t = 0; m_cnt = 0;
      m_en = 0; m_inv = 0; m_full = 0; m_far = 0; m_late = 0; m_fill = '0;
   endtask

   // one clock: drive a beat, predict from rules, compare registered outputs after the edge
   task automatic beat(input bit v, input logic [`DTYPE_WIDTH-1:0] dt);
      logic [NC*PW-1:0] d, exp_d;
      logic [15:0] meta;
      int pr, pc, dx;
      bit pass, early, exp_sv;
      int exp_cnt;
      for (int ch = 0; ch < NC; ch++) d[ch*PW +: PW] = PW'($urandom_range(1, (1 << PW) - 1));
      meta = 16'($urandom);
      dvi = v; dtypei = dt; datai = d; meta_datai = meta;
      exp_d = d; exp_sv = 0; exp_cnt = 0; pr = m_row; pc = m_col;
      if (v) begin
         if (dt == FS) begin
            m_en = enable; m_inv = invert; m_r = int'(radius); m_fill = fill;
            m_full = auto_center && (m_cols_meas == 0 || m_rows_meas == 0);
            m_cx = auto_center ? m_cols_meas / 2 : int'(center_col);
            m_cy = auto_center ? m_rows_meas / 2 : int'(center_row);
            m_row = 0; m_col = 0; m_late = 0; m_cnt = 0;
         end else if (dt == RS) begin
            m_dy = iabs(m_row - m_cy); m_far = m_dy > m_r; m_rs_t = cyc;
         end else if (dt == PX) begin
            pass = 1;
            if (m_en && !m_full) begin
               dx = iabs(m_col - m_cx);
               early = (cyc - m_rs_t) < DW + 2;
               if (!m_far && early) m_late = 1;
               pass = (!m_far && !early && (dx * dx + m_dy * m_dy <= m_r * m_r)) ^ m_inv;
            end
            if (!pass) exp_d = {NC{m_fill}};
            else m_cnt++;
            m_col++;
         end else if (dt == RE) begin
            m_cols_meas = m_col; m_col = 0; m_row++;
         end else if (dt == FE) begin
            m_rows_meas = m_row; exp_sv = 1; exp_cnt = m_cnt;
         end
      end
      @(posedge clk); #1;
      cyc++;
      check("dvo", 64'(dvo), 64'(v));
      if (v) begin
         check("datao", 64'(datao), 64'(exp_d));
         check("dtypeo", 64'(dtypeo), 64'(dt));
         check("meta_datao", 64'(meta_datao), 64'(meta));
      end
      check("late_bound", 64'(late_bound), 64'(m_late));
`ifdef CIRCLE_MASK_STATS_EN
      check("stats_valid", 64'(stats_valid), 64'(exp_sv));
      if (exp_sv) check("pass_count", 64'(pass_count), 64'(exp_cnt));
`endif
      if (v && dt == PX && cap_sel >= 0 && pr < 16 && pc < 16)
         rec[cap_sel][pr][pc] = (datao == d);
   endtask

   task automatic run_frame(input int rows, input int cols, input int gap, input int blank, input int toggle_row);
      beat(1, FS);
      for (int r = 0; r < rows; r++) begin
         if (r == toggle_row) enable = ~enable;
         beat(1, RS);
         repeat (gap) beat(0, '0);
         repeat (cols) beat(1, PX);
         beat(1, RE);
         repeat (blank) beat(0, '0);
      end
      beat(1, FE);
      beat(0, '0);
   endtask

   task automatic set_cfg(input bit en, input bit au, input bit inv, input int cx, input int cy,
                          input int r, input logic [PW-1:0] f);
      enable = en; auto_center = au; invert = inv;
      center_col = DW'(cx); center_row = DW'(cy); radius = DW'(r); fill = f;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dvo"}, 64'(dvo), 64'd0);
      check({tag, "_datao"}, 64'(datao), 64'd0);
      check({tag, "_dtypeo"}, 64'(dtypeo), 64'd0);
      check({tag, "_meta"}, 64'(meta_datao), 64'd0);
      check({tag, "_late"}, 64'(late_bound), 64'd0);
`ifdef CIRCLE_MASK_STATS_EN
      check({tag, "_pass_count"}, 64'(pass_count), 64'd0);
      check({tag, "_stats_valid"}, 64'(stats_valid), 64'd0);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{4, 1, 1}; tbl[1]  = '{4, 0, 0}; tbl[2]  = '{1, 4, 1}; tbl[3]  = '{1, 3, 0};
      tbl[4]  = '{0, 4, 0}; tbl[5]  = '{7, 4, 1}; tbl[6]  = '{7, 3, 0}; tbl[7]  = '{2, 2, 1};
      tbl[8]  = '{2, 1, 0}; tbl[9]  = '{4, 7, 1}; tbl[10] = '{6, 6, 1}; tbl[11] = '{6, 7, 0};

      cyc = 0;
      model_reset();
      resetb = 1'b0; dvi = 0; dtypei = '0; datai = '0; meta_datai = '0;
      set_cfg(1, 0, 0, 4, 4, 3, '0);
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk) resetb = 1'b1;

      // manual centre (4,4) r=3, probe table
      cap_sel = 0;
      run_frame(8, 8, 20, 20, -1);
      for (int i = 0; i < 12; i++)
         check($sformatf("probe_r%0d_c%0d", tbl[i].row, tbl[i].col),
               64'(rec[0][tbl[i].row][tbl[i].col]), 64'(tbl[i].pass));

      // invert with fill=0x3FF: exact complement of the previous frame
      set_cfg(1, 0, 1, 4, 4, 3, 10'h3FF);
      cap_sel = 1;
      run_frame(8, 8, 20, 20, -1);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            check($sformatf("complement_r%0d_c%0d", r, c), 64'(rec[1][r][c]), 64'(!rec[0][r][c]));
      cap_sel = -1;

      // enable dropped mid-frame applies only from the next frame
      set_cfg(1, 0, 0, 4, 4, 3, '0);
      run_frame(8, 8, 20, 4, 3);
      run_frame(8, 8, 20, 4, -1);

      // short ROW_START-to-pixel gap: leading pixels masked, sticky late_bound
      set_cfg(1, 0, 0, 8, 4, 6, '0);
      run_frame(8, 16, 4, 6, -1);
      check("late_sticky", 64'(late_bound), 64'd1);
      run_frame(4, 16, 20, 4, -1);
      check("late_cleared", 64'(late_bound), 64'd0);

      // radius 0 keeps only the centre pixel
      set_cfg(1, 0, 0, 2, 2, 0, '0);
      cap_sel = 3;
      run_frame(5, 5, 20, 2, -1);
      check("r0_centre", 64'(rec[3][2][2]), 64'd1);
      check("r0_left", 64'(rec[3][2][1]), 64'd0);
      check("r0_above", 64'(rec[3][1][2]), 64'd0);
      cap_sel = -1;

      // reset mid-row clears outputs immediately
      set_cfg(1, 0, 0, 4, 4, 3, 10'h155);
      beat(1, FS); beat(1, RS);
      repeat (20) beat(0, '0);
      repeat (3) beat(1, PX);
      #2 resetb = 1'b0;
      dvi = 0;
      #1 check_reset_outputs("midrow_reset");
      repeat (2) @(posedge clk);
      #2 resetb = 1'b1;
      model_reset();

      // auto centre: first frame after reset passes, next uses measured (8,6)
      set_cfg(1, 1, 0, 0, 0, 5, '0);
      cap_sel = 2;
      run_frame(12, 16, 20, 3, -1);
      check("auto_f0_corner", 64'(rec[2][0][0]), 64'd1);
      check("auto_f0_far", 64'(rec[2][11][15]), 64'd1);
      run_frame(12, 16, 20, 3, -1);
      check("auto_f1_centre", 64'(rec[2][6][8]), 64'd1);
      check("auto_f1_edge", 64'(rec[2][6][3]), 64'd1);
      check("auto_f1_out", 64'(rec[2][6][2]), 64'd0);
      check("auto_f1_corner", 64'(rec[2][0][0]), 64'd0);
      cap_sel = -1;

      // randomized frames against the model
      for (int f = 0; f < 8; f++) begin
         set_cfg($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 20), $urandom_range(0, 16), $urandom_range(0, 12),
                 PW'($urandom));
         run_frame($urandom_range(3, 10), $urandom_range(3, 14), $urandom_range(2, 20),
                   $urandom_range(1, 6), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
